tdm_demux4: RTL and testbench

TDM_DEMUX4 -- requirements
Module: tdm_demux4

---
 rtl/tdm_pkg.sv | 29 ++
 rtl/tdm_lane_sreg.sv | 35 +++
 rtl/tdm_demux4.sv | 155 +++++++++++++++
 tb/tb_tdm_demux4.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared definitions for the 4-lane TDM demultiplexer.
//   state_t    : alignment FSM states (HUNT, LOCK)
//   NLANES     : number of TDM lanes per frame
//   SLOTS_STD  : slots per frame without the parity slot
//   SLOTS_PAR  : slots per frame with the parity slot (TDM_PARITY_CHECK_EN)
//   next_sel() : lane index for the next qualified bit
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int NLANES    = 4;
  localparam int SLOTS_STD = 4;
  localparam int SLOTS_PAR = 5;

  // With a parity slot, sel parks at 3 for one extra bit (the parity bit)
  // before wrapping back to lane 0.
  function automatic logic [1:0] next_sel(input logic [1:0] sel,
                                          input logic       par_slot,
                                          input logic       par_en);
    if (!par_en)       return sel + 2'd1;
    if (par_slot)      return 2'd0;
    if (sel == 2'd3)   return 2'd3;
    return sel + 2'd1;
  endfunction

endpackage

// File: rtl/tdm_lane_sreg.sv
// tdm_lane_sreg: one lane's WIDTH-bit MSB-first deserializing shift register.
// Ports:
//   clk       : clock
//   clr       : discard the partial word (combined with shift, the incoming
//               bit becomes the first bit of a fresh word)
//   shift     : shift bit_in into the LSB end
//   bit_in    : serial data bit
//   next_word : register contents after this cycle's clr/shift; the parent
//               captures the completed word from here so the final bit
//               lands in the output word with one cycle of latency.
// The shift register holds only data, so it carries no reset: every word is
// rebuilt by WIDTH shifts after a clear.
module tdm_lane_sreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             shift,
  input  logic             bit_in,
  output logic [WIDTH-1:0] next_word
);

  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] base;

  always_comb begin
    base      = clr ? '0 : word;
    next_word = shift ? {base[WIDTH-2:0], bit_in} : base;
  end

  always_ff @(posedge clk) begin
    word <= next_word;
  end

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: serial TDM stream to four parallel lane words.
// A frame carries one bit per lane (slot k -> lane k), MSB first; WIDTH
// frames build one word per lane. An fsync with a qualified bit marks slot 0.
// Optional feature macro: TDM_PARITY_CHECK_EN adds a fifth (even parity)
// slot per frame and drives par_err on mismatch; otherwise par_err is 0.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   din, din_en      : serial data bit and its qualifier
//   fsync            : frame marker (only meaningful with din_en=1)
//   q0..q3           : deserialized lane words, held between valid pulses
//   sel              : lane expected for the next qualified bit
//   valid            : one-cycle pulse when q0..q3 are updated
//   locked           : high while frame alignment is held
//   sync_err         : one-cycle pulse on an fsync at the wrong slot
//   par_err          : one-cycle pulse on a parity mismatch
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_en,
  input  logic             fsync,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [1:0]       sel,
  output logic             valid,
  output logic             locked,
  output logic             sync_err,
  output logic             par_err
);

`ifdef TDM_PARITY_CHECK_EN
  localparam int FRAME_SLOTS = SLOTS_PAR;
`else
  localparam int FRAME_SLOTS = SLOTS_STD;
`endif
  localparam logic PAR_EN = (FRAME_SLOTS == SLOTS_PAR);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] FRAME_LAST = CW'(WIDTH - 1);

  state_t            state;
  logic [CW-1:0]     frame_cnt;
  logic              par_slot;
  logic              last_slot;
  logic              misplaced;
  logic              restart;
  logic              step;
  logic              done;
  logic [NLANES-1:0] lane_shift;
  logic [WIDTH-1:0]  lane_nxt [NLANES];

  // A restart (first fsync in HUNT, or a misplaced fsync in LOCK) makes the
  // current bit slot 0 of a brand-new word; otherwise a qualified bit in LOCK
  // is an ordinary step through the frame.
  always_comb begin
`ifdef TDM_PARITY_CHECK_EN
    last_slot = par_slot;
`else
    last_slot = (sel == 2'd3);
`endif
    misplaced = (sel != 2'd0) || par_slot;
    restart   = din_en && fsync && ((state == HUNT) || misplaced);
    step      = din_en && (state == LOCK) && !restart;
    done      = step && last_slot && (frame_cnt == FRAME_LAST);
    for (int k = 0; k < NLANES; k++) begin
      lane_shift[k] = restart ? (k == 0)
                              : (step && !par_slot && (sel == k[1:0]));
    end
  end

  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    tdm_lane_sreg #(.WIDTH(WIDTH)) u_sreg (
      .clk       (clk),
      .clr       (restart),
      .shift     (lane_shift[g]),
      .bit_in    (din),
      .next_word (lane_nxt[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      locked    <= 1'b0;
      sel       <= 2'd0;
      frame_cnt <= '0;
      valid     <= 1'b0;
      sync_err  <= 1'b0;
      q0        <= '0;
      q1        <= '0;
      q2        <= '0;
      q3        <= '0;
    end else begin
      valid    <= 1'b0;
      sync_err <= 1'b0;
      if (restart) begin
        // A restart from LOCK is by definition a misplaced fsync.
        sync_err  <= (state == LOCK);
        state     <= LOCK;
        locked    <= 1'b1;
        sel       <= 2'd1;
        frame_cnt <= '0;
      end else if (step) begin
        sel <= next_sel(sel, par_slot, PAR_EN);
        if (last_slot) begin
          frame_cnt <= done ? '0 : frame_cnt + CW'(1);
        end
        if (done) begin
          valid <= 1'b1;
          q0    <= lane_nxt[0];
          q1    <= lane_nxt[1];
          q2    <= lane_nxt[2];
          q3    <= lane_nxt[3];
        end
      end
    end
  end

`ifdef TDM_PARITY_CHECK_EN
  logic par_acc;

  // par_acc accumulates the XOR of slots 0..3; the slot-4 bit must equal it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_slot <= 1'b0;
      par_acc  <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      par_err <= 1'b0;
      if (restart) begin
        par_slot <= 1'b0;
        par_acc  <= din;
      end else if (step) begin
        if (par_slot) begin
          par_slot <= 1'b0;
          par_err  <= (din != par_acc);
        end else begin
          par_slot <= (sel == 2'd3);
          par_acc  <= (sel == 2'd0) ? din : (par_acc ^ din);
        end
      end
    end
  end
`else
  assign par_slot = 1'b0;
  assign par_err  = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;

  localparam int W = 8;
`ifdef TDM_PARITY_CHECK_EN
  localparam int SLOTS   = 5;
  localparam int EXP_PAR = 1;
`else
  localparam int SLOTS   = 4;
  localparam int EXP_PAR = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  logic din_en = 1'b0;
  logic fsync = 1'b0;
  logic [W-1:0] q0, q1, q2, q3;
  logic [1:0] sel;
  logic valid, locked, sync_err, par_err;

  int nchk = 0;
  int nerr = 0;
  int sync_cnt = 0;
  int par_cnt = 0;
  logic [4*W-1:0] sb[$];
  logic [4*W-1:0] exp_w;

  always #5 clk = ~clk;

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .din_en   (din_en),
    .fsync    (fsync),
    .q0       (q0),
    .q1       (q1),
    .q2       (q2),
    .q3       (q3),
    .sel      (sel),
    .valid    (valid),
    .locked   (locked),
    .sync_err (sync_err),
    .par_err  (par_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        if (sb.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_valid: got q=%h %h %h %h expected no valid", q0, q1, q2, q3);
        end else begin
          exp_w = sb.pop_front();
          chk("q0", 32'(q0), 32'(exp_w[4*W-1:3*W]));
          chk("q1", 32'(q1), 32'(exp_w[3*W-1:2*W]));
          chk("q2", 32'(q2), 32'(exp_w[2*W-1:W]));
          chk("q3", 32'(q3), 32'(exp_w[W-1:0]));
        end
        chk("valid_sync_exclusive", 32'(sync_err), 32'd0);
      end
      if (sync_err) sync_cnt++;
      if (par_err)  par_cnt++;
    end
  end

  task automatic send_bit(input logic b, input logic fs);
    din    = b;
    fsync  = fs;
    din_en = 1'b1;
    @(posedge clk);
    #1;
    din_en = 1'b0;
    fsync  = 1'b0;
    din    = 1'b0;
  endtask

  // Unqualified cycle: fsync and din are deliberately active and must be ignored.
  task automatic idle();
    din   = 1'b1;
    fsync = 1'b1;
    @(posedge clk);
    #1;
    din   = 1'b0;
    fsync = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w0, input logic [W-1:0] w1,
                           input logic [W-1:0] w2, input logic [W-1:0] w3,
                           input logic first_fs, input logic gap, input int bad_frame);
    logic [W-1:0] w [4];
    logic p, b, last;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    sb.push_back({w0, w1, w2, w3});
    for (int f = 0; f < W; f++) begin
      p = 1'b0;
      for (int k = 0; k < 4; k++) begin
        b = w[k][W-1-f];
        p = p ^ b;
        send_bit(b, first_fs && (f == 0) && (k == 0));
        last = (f == W-1) && (k == 3) && (SLOTS == 4);
        chk("valid_timing", 32'(valid), 32'(last));
        if (gap) idle();
      end
      if (SLOTS == 5) begin
        send_bit(p ^ (f == bad_frame), 1'b0);
        chk("valid_timing", 32'(valid), 32'(f == W-1));
        if (gap) idle();
      end
    end
  endtask

  // Filler bit for partial words: ones in data slots, zero in the parity slot
  // (even parity of four ones), so partial frames never raise par_err.
  function automatic logic fill_bit(input int i);
    return !((SLOTS == 5) && (i % 5 == 4));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    chk("rst_q0", 32'(q0), 0);
    chk("rst_q3", 32'(q3), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_sync_err", 32'(sync_err), 0);
    chk("rst_par_err", 32'(par_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Data before any fsync is discarded
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
    chk("hunt_locked", 32'(locked), 0);
    chk("hunt_sel", 32'(sel), 0);

    // Back-to-back qualified bits, fsync on the first bit
    send_word(8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b1, 1'b0, -1);
    chk("locked_after_word", 32'(locked), 1);
    repeat (3) idle();
    chk("hold_q0", 32'(q0), 32'h A5);
    chk("hold_q1", 32'(q1), 32'h 3C);
    chk("hold_q2", 32'(q2), 32'h FF);
    chk("hold_q3", 32'(q3), 32'h 00);

    // Same stream with din_en low every other cycle
    send_word(8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b1, 1'b1, -1);
    send_word(8'h5A, 8'hC3, 8'h01, 8'h80, 1'b0, 1'b1, -1);
    chk("no_sync_err_yet", 32'(sync_cnt), 0);

    // Misplaced fsync at sel=2 in frame 3
    for (int i = 0; i < 3*SLOTS + 2; i++) send_bit(fill_bit(i), i == 0);
    chk("sel_before_misplaced", 32'(sel), 2);
    send_word(8'h12, 8'h34, 8'h56, 8'h78, 1'b1, 1'b0, -1);
    chk("sync_err_count", 32'(sync_cnt), 1);

    // Reset in mid-word
    for (int i = 0; i < 17; i++) send_bit(fill_bit(i), i == 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_q0", 32'(q0), 0);
    chk("midrst_q1", 32'(q1), 0);
    chk("midrst_q2", 32'(q2), 0);
    chk("midrst_q3", 32'(q3), 0);
    chk("midrst_sel", 32'(sel), 0);
    chk("midrst_locked", 32'(locked), 0);
    chk("midrst_valid", 32'(valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_bit(1'b1, 1'b0);
    chk("postrst_hunt", 32'(locked), 0);
    send_word(8'h9E, 8'h61, 8'h0F, 8'hF0, 1'b1, 1'b0, -1);

`ifdef TDM_PARITY_CHECK_EN
    // Corrupted parity slot in frame 5
    send_word(8'hC7, 8'h2B, 8'h90, 8'h6D, 1'b0, 1'b0, 5);
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 0);
    chk("par_err_count", 32'(par_cnt), 32'(EXP_PAR));
    chk("sync_err_final", 32'(sync_cnt), 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
